// File: rtl/mem_test_master_if.sv
// Avalon-MM bus between the memory test master and the memory under test.
interface mem_test_master_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/mem_test_master.sv
// Memory test master: fills a word range with seed+i, or reads it back and counts mismatches.
module mem_test_master #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_test_master_if.master bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrite   = 3'd1;
  localparam logic [2:0] StRdIssue = 3'd2;
  localparam logic [2:0] StRdWait  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [1:0]      LatInit = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0] OneWord = (ADDR_W + 1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = base_addr;
          data_d = seed;
          rem_d  = word_count;
          err_d  = '0;
          ferr_d = '0;
          if (word_count == '0) state_d = StDone;
          else if (mode)        state_d = StRdIssue;
          else                  state_d = StWrite;
        end
      end
      StWrite: begin
        if (!bus.avm_waitrequest) begin
          addr_d = addr_q + 1'b1;
          data_d = data_q + 32'd1;
          rem_d  = rem_q - OneWord;
          if (rem_q == OneWord) state_d = StDone;
        end
      end
      StRdIssue: begin
        if (!bus.avm_waitrequest) begin
          lat_d   = LatInit;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // data_q doubles as the expected word for the read in flight
        if (lat_q != 2'd0) begin
          lat_d = lat_q - 2'd1;
        end else begin
          if (bus.avm_readdata != data_q) begin
            err_d = err_q + OneWord;
            if (err_q == '0) ferr_d = addr_q;
          end
          addr_d  = addr_q + 1'b1;
          data_d  = data_q + 32'd1;
          rem_d   = rem_q - OneWord;
          state_d = (rem_q == OneWord) ? StDone : StRdIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign busy           = (state_q == StWrite) || (state_q == StRdIssue) || (state_q == StRdWait);
  assign done           = (state_q == StDone);
  assign error_count    = err_q;
  assign first_err_addr = ferr_q;

  assign bus.avm_chipselect = (state_q == StWrite) || (state_q == StRdIssue);
  assign bus.avm_write      = (state_q == StWrite);
  assign bus.avm_read       = (state_q == StRdIssue);
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;

endmodule

// File: tb/tb_mem_test_master.sv
// Directed bench: fill, verify with a corrupted word, waitrequest stall, address wrap, abort.
module tb_mem_test_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [12:0] error_count;
  logic [11:0] first_err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_test_master_if #(.ADDR_W(12)) bus ();

  mem_test_master #(.ADDR_W(12), .READ_LATENCY(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // 1-latency RAM model with optional corruption of word 2 and a write stall at 0x011
  logic [31:0] mem [4096];
  logic [31:0] rd_q;
  logic        corrupt;
  logic        stall_arm;
  logic [1:0]  stall_q;
  int          wr_count = 0;

  assign bus.avm_readdata    = rd_q;
  assign bus.avm_waitrequest = stall_arm && bus.avm_write && (bus.avm_address == 12'h011) &&
                               (stall_q != 2'd3);

  always_ff @(posedge clk) begin
    if (!stall_arm) stall_q <= 2'd0;
    else if (bus.avm_waitrequest) stall_q <= stall_q + 2'd1;
    if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest) begin
      mem[bus.avm_address] <= bus.avm_writedata;
      wr_count <= wr_count + 1;
    end
    if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest)
      rd_q <= mem[bus.avm_address] ^ ((corrupt && bus.avm_address == 12'h002) ? 32'h0F00 : 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start_cmd(input logic m, input logic [11:0] b, input logic [12:0] c,
                           input logic [31:0] s);
    start = 1'b1; mode = m; base_addr = b; word_count = c; seed = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [11:0] ea;
    logic [11:0] st_addr [7];
    logic [31:0] st_data [7];
    int w0;

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    corrupt = 1'b0; stall_arm = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cs", 32'(bus.avm_chipselect), 32'h0);
    check("rst_addr", 32'(bus.avm_address), 32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    check("rst_be", 32'(bus.avm_byteenable), 32'hF);
    check("rst_errcnt", 32'(error_count), 32'h0);
    check("rst_ferr", 32'(first_err_addr), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill: one write per cycle, done on cycle 5
    start_cmd(1'b0, 12'h000, 13'd4, 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("fill_write", 32'(bus.avm_write), 32'h1);
      check("fill_read", 32'(bus.avm_read), 32'h0);
      check("fill_addr", 32'(bus.avm_address), 32'(i));
      check("fill_data", bus.avm_writedata, 32'h100 + 32'(i));
      check("fill_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    check("fill_done", 32'(done), 32'h1);
    check("fill_done_busy", 32'(busy), 32'h0);
    check("fill_done_cs", 32'(bus.avm_chipselect), 32'h0);
    @(negedge clk);
    check("fill_done_pulse", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) check("fill_mem", mem[i], 32'h100 + 32'(i));

    // Verify with word 2 corrupted: one read every two cycles
    corrupt = 1'b1;
    start_cmd(1'b1, 12'h000, 13'd4, 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("vfy_read", 32'(bus.avm_read), 32'h1);
      check("vfy_write", 32'(bus.avm_write), 32'h0);
      check("vfy_addr", 32'(bus.avm_address), 32'(i));
      @(negedge clk);
      check("vfy_wait_read", 32'(bus.avm_read), 32'h0);
      check("vfy_wait_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    check("vfy_done", 32'(done), 32'h1);
    check("vfy_errcnt", 32'(error_count), 32'h1);
    check("vfy_ferr", 32'(first_err_addr), 32'h2);
    repeat (2) @(negedge clk);
    check("vfy_hold_errcnt", 32'(error_count), 32'h1);
    check("vfy_hold_ferr", 32'(first_err_addr), 32'h2);
    corrupt = 1'b0;

    // Waitrequest for 3 cycles on write 1
    st_addr = '{12'h010, 12'h011, 12'h011, 12'h011, 12'h011, 12'h012, 12'h013};
    st_data = '{32'h55, 32'h56, 32'h56, 32'h56, 32'h56, 32'h57, 32'h58};
    stall_arm = 1'b1;
    w0 = wr_count;
    start_cmd(1'b0, 12'h010, 13'd4, 32'h55);
    for (int i = 0; i < 7; i++) begin
      check("wait_write", 32'(bus.avm_write), 32'h1);
      check("wait_addr", 32'(bus.avm_address), 32'(st_addr[i]));
      check("wait_data", bus.avm_writedata, st_data[i]);
      @(negedge clk);
    end
    check("wait_done", 32'(done), 32'h1);
    check("wait_wr_count", 32'(wr_count - w0), 32'd4);
    for (int i = 0; i < 4; i++) check("wait_mem", mem[16 + i], 32'h55 + 32'(i));
    stall_arm = 1'b0;
    @(negedge clk);

    // Address wrap; a start pulse mid-command must be ignored
    start_cmd(1'b0, 12'hFFE, 13'd4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ea = 12'hFFE + 12'(i);
      check("wrap_addr", 32'(bus.avm_address), 32'(ea));
      check("wrap_data", bus.avm_writedata, 32'(i));
      check("wrap_write", 32'(bus.avm_write), 32'h1);
      if (i == 1) begin
        start = 1'b1; mode = 1'b1; base_addr = 12'h005; word_count = 13'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("wrap_done", 32'(done), 32'h1);
    check("wrap_mem0", mem[0], 32'h2);
    check("wrap_mem_fff", mem[12'hFFF], 32'h1);
    @(negedge clk);

    // Abort mid-verify; then a zero-length command
    start_cmd(1'b1, 12'h000, 13'd4, 32'h100);
    repeat (2) @(negedge clk);
    check("abort_pre_read", 32'(bus.avm_read), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort_read", 32'(bus.avm_read), 32'h0);
    check("abort_cs", 32'(bus.avm_chipselect), 32'h0);
    check("abort_write", 32'(bus.avm_write), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resume", 32'(busy), 32'h0);
      check("abort_no_read", 32'(bus.avm_read), 32'h0);
    end
    start_cmd(1'b1, 12'h123, 13'd0, 32'h0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    check("zero_errcnt", 32'(error_count), 32'h0);
    check("zero_cs", 32'(bus.avm_chipselect), 32'h0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_test_master.md
MEM_TEST_MASTER -- requirements
Module: mem_test_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width of the target memory.
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning fixed cycles from read acceptance to valid avm_readdata (range 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = fill, 1 = verify; captured with start.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address; captured with start.
REQ-008 SHALL have port word_count  input  ADDR_W+1  words to process (0..2^ADDR_W); captured with start.
REQ-009 SHALL have port seed  input  32  pattern seed; captured with start.
REQ-010 SHALL have port busy  output  1  high while a command is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at command completion.
REQ-012 SHALL have port error_count  output  ADDR_W+1  verify mismatches in the last command.
REQ-013 SHALL have port first_err_addr  output  ADDR_W  address of the first mismatch in the last command.
REQ-014 SHALL have ports avm_address (output, ADDR_W), avm_byteenable (output, 4), avm_chipselect (output, 1), avm_write (output, 1), avm_read (output, 1), avm_writedata (output, 32): Avalon-MM master command signals.
REQ-015 SHALL have ports avm_readdata (input, 32) and avm_waitrequest (input, 1): Avalon-MM master response signals.

Function
REQ-016 SHALL implement states IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE.
REQ-017 SHALL generate the word at index i (0-based) as seed + i, modulo 2^32, at address (base_addr + i) mod 2^ADDR_W; addresses wrap with no error.
REQ-018 SHALL, on start in IDLE, capture all command inputs, clear error_count and first_err_addr, and enter WRITE (mode 0) or RD_ISSUE (mode 1) on the next edge.
REQ-019 SHALL, with start and word_count = 0, enter DONE directly with error_count = 0.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL hold avm_chipselect and avm_write high in WRITE, with avm_byteenable = 4'hF and current address/data held stable while avm_waitrequest is high.
REQ-022 SHALL treat a write as accepted on any edge where avm_write = 1 and avm_waitrequest = 0, then advance i, sustaining one write per cycle with no waitrequest.
REQ-023 SHALL hold avm_chipselect and avm_read high in RD_ISSUE until accepted (avm_waitrequest = 0), then enter RD_WAIT with avm_read low.
REQ-024 SHALL sample avm_readdata exactly READ_LATENCY cycles after read acceptance and compare it with the expected word, keeping at most one read outstanding.
REQ-025 SHALL increment error_count on mismatch and latch first_err_addr on the first mismatch only.
REQ-026 SHALL return to RD_ISSUE after each compare if words remain; otherwise it SHALL enter DONE.
REQ-027 SHALL never assert avm_write and avm_read in the same cycle, and SHALL drive avm_chipselect low in IDLE and DONE.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy SHALL be high in WRITE, RD_ISSUE and RD_WAIT and low in IDLE and DONE.
REQ-029 SHALL keep error_count and first_err_addr stable from DONE until the next accepted start.

Reset
REQ-030 SHALL, on reset_n low (asynchronous, including mid-command), enter IDLE and drive busy, done, avm_chipselect, avm_write and avm_read to 0.
REQ-031 SHALL, on reset_n low, reset error_count, first_err_addr, avm_address and avm_writedata to 0 and avm_byteenable to 4'hF.
REQ-032 SHALL not resume an aborted command after reset release.

Verification
REQ-033 SHALL pass fill: mode 0, base 0, count 4, seed 0x100, no waitrequest, start at cycle 0 -> writes 0x100..0x103 at addresses 0..3 on cycles 1..4, done on cycle 5.
REQ-034 SHALL pass wrap: mode 0, base 0xFFE, count 4, seed 0 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 SHALL pass verify against a 1-latency RAM model pre-filled by REQ-033 with word 2 corrupted -> error_count 1, first_err_addr 2, one read per 2 cycles.
REQ-036 SHALL pass waitrequest: waitrequest high for 3 cycles on write 1 -> address and data held for those 3 cycles, no word skipped or duplicated.
REQ-037 SHALL pass abort: reset_n low mid-verify -> all strobes 0 immediately; a later start with count 0 -> done one cycle after entering DONE with error_count 0.
